// File: rtl/nt_dopamine_reader.sv
// nt_dopamine_reader: consumer end of the dopamine channel.
//
// This block samples the 2-bit downscaled dopamine level and debounces it into a
// stable motivation state. When a new level is accepted it emits a one-cycle
// reward pulse (on an increase) or a letdown pulse (on a decrease). Reward pulses
// are blocked during a refractory interval that starts after each emitted reward.
// Craving is flagged once motivation has stayed at zero long enough.
//
// Ports:
//   clk            in   system clock (rising edge)
//   rst_n          in   synchronous, active-low reset
//   dopamine_level in   [1:0] downscaled dopamine level
//   motivation     out  [1:0] debounced, accepted level
//   reward_pulse   out  one-cycle pulse on an accepted increase (refractory-gated)
//   letdown_pulse  out  one-cycle pulse on an accepted decrease
//   craving        out  high while motivation has been 0 for >= CRAVE_CYCLES cycles
//   trend          out  [1:0] direction of the last accepted change
//                       (present only when NT_DOPAMINE_READER_TREND_EN is defined)
//
// Optional feature macro: NT_DOPAMINE_READER_TREND_EN adds the trend output.

module nt_dopamine_reader #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned REFRACTORY   = 8,
  parameter int unsigned CRAVE_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dopamine_level,
  output logic [1:0] motivation,
  output logic       reward_pulse,
  output logic       letdown_pulse,
  output logic       craving
`ifdef NT_DOPAMINE_READER_TREND_EN
  ,
  output logic [1:0] trend
`endif
);

  localparam logic [7:0] HoldMax  = 8'(HOLD_CYCLES);
  localparam logic [7:0] RefrLoad = 8'(REFRACTORY);
  localparam logic [7:0] CraveMax = 8'(CRAVE_CYCLES);

  logic [1:0] cand_q, cand_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] mot_q, mot_d;
  logic [7:0] refr_q, refr_d;
  logic [7:0] crave_q, crave_d;
  logic       reward_q, reward_d;
  logic       letdown_q, letdown_d;
  logic       craving_q, craving_d;
`ifdef NT_DOPAMINE_READER_TREND_EN
  logic [1:0] trend_q, trend_d;
`endif

  logic       commit;
  logic [1:0] commit_val;

  always_comb begin
    // Debounce: a level must be seen HOLD_CYCLES times in a row to commit.
    cand_d     = cand_q;
    hold_d     = hold_q;
    commit     = 1'b0;
    commit_val = cand_q;
    if (dopamine_level != cand_q) begin
      cand_d = dopamine_level;
      hold_d = 8'd1;
      if (HoldMax == 8'd1) begin
        commit     = 1'b1;
        commit_val = dopamine_level;
      end
    end else if (hold_q < HoldMax) begin
      hold_d = hold_q + 8'd1;
      if (hold_d == HoldMax) begin
        commit = 1'b1;
      end
    end

    mot_d     = mot_q;
    reward_d  = 1'b0;
    letdown_d = 1'b0;
    refr_d    = (refr_q != 8'd0) ? refr_q - 8'd1 : refr_q;
`ifdef NT_DOPAMINE_READER_TREND_EN
    trend_d   = trend_q;
`endif

    if (commit) begin
      mot_d = commit_val;
      if (commit_val > mot_q) begin
        // A suppressed reward neither pulses nor extends the refractory interval.
        if (refr_q == 8'd0) begin
          reward_d = 1'b1;
          refr_d   = RefrLoad;
        end
`ifdef NT_DOPAMINE_READER_TREND_EN
        trend_d = 2'b01;
`endif
      end else if (commit_val < mot_q) begin
        letdown_d = 1'b1;
`ifdef NT_DOPAMINE_READER_TREND_EN
        trend_d   = 2'b10;
`endif
      end
    end

    // Craving tracks the registered motivation, so it lags commits by one edge.
    if (mot_q == 2'd0) begin
      crave_d = (crave_q == CraveMax) ? crave_q : crave_q + 8'd1;
    end else begin
      crave_d = 8'd0;
    end
    craving_d = (crave_d == CraveMax);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q    <= 2'b10;
      hold_q    <= HoldMax;
      mot_q     <= 2'b10;
      refr_q    <= 8'd0;
      crave_q   <= 8'd0;
      reward_q  <= 1'b0;
      letdown_q <= 1'b0;
      craving_q <= 1'b0;
`ifdef NT_DOPAMINE_READER_TREND_EN
      trend_q   <= 2'b00;
`endif
    end else begin
      cand_q    <= cand_d;
      hold_q    <= hold_d;
      mot_q     <= mot_d;
      refr_q    <= refr_d;
      crave_q   <= crave_d;
      reward_q  <= reward_d;
      letdown_q <= letdown_d;
      craving_q <= craving_d;
`ifdef NT_DOPAMINE_READER_TREND_EN
      trend_q   <= trend_d;
`endif
    end
  end

  assign motivation    = mot_q;
  assign reward_pulse  = reward_q;
  assign letdown_pulse = letdown_q;
  assign craving       = craving_q;
`ifdef NT_DOPAMINE_READER_TREND_EN
  assign trend         = trend_q;
`endif

endmodule

// File: tb/tb_nt_dopamine_reader.sv
// Testbench for nt_dopamine_reader: directed vector table, hand-written craving
// sequence and randomized stimulus checked against a behavioural model.

module tb_nt_dopamine_reader;

  localparam int unsigned Hold  = 4;
  localparam int unsigned Refr  = 8;
  localparam int unsigned Crave = 200;

  logic       clk;
  logic       rst_n;
  logic [1:0] dopamine_level;
  logic [1:0] motivation;
  logic       reward_pulse;
  logic       letdown_pulse;
  logic       craving;
`ifdef NT_DOPAMINE_READER_TREND_EN
  logic [1:0] trend;
`endif

  nt_dopamine_reader #(
    .HOLD_CYCLES (Hold),
    .REFRACTORY  (Refr),
    .CRAVE_CYCLES(Crave)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dopamine_level(dopamine_level),
    .motivation    (motivation),
    .reward_pulse  (reward_pulse),
    .letdown_pulse (letdown_pulse),
    .craving       (craving)
`ifdef NT_DOPAMINE_READER_TREND_EN
    ,
    .trend         (trend)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Behavioural model state.
  int hist[$];        // last Hold+1 samples, oldest first
  int m_mot;
  int m_rew;
  int m_let;
  int m_crv;
  int m_trend;
  int m_last_reward;  // edge index of the last emitted reward
  int m_zero_run;     // consecutive edges that saw motivation == 0

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic model_edge(input int lvl, input bit rst);
    int prev;
    bit stable;
    edge_no++;
    m_rew = 0;
    m_let = 0;
    if (!rst) begin
      hist.delete();
      for (int i = 0; i <= int'(Hold); i++) hist.push_back(2);
      m_mot         = 2;
      m_crv         = 0;
      m_trend       = 0;
      m_zero_run    = 0;
      m_last_reward = -100000;
      return;
    end
    hist.push_back(lvl);
    void'(hist.pop_front());
    prev = m_mot;
    m_zero_run = (prev == 0) ? m_zero_run + 1 : 0;
    // A level is accepted on the edge its run first reaches Hold identical samples.
    stable = 1'b1;
    for (int i = 1; i <= int'(Hold); i++) if (hist[i] != lvl) stable = 1'b0;
    if (stable && hist[0] != lvl) begin
      if (lvl > prev) begin
        m_trend = 1;
        if (edge_no - m_last_reward > int'(Refr)) begin
          m_rew = 1;
          m_last_reward = edge_no;
        end
      end else if (lvl < prev) begin
        m_trend = 2;
        m_let = 1;
      end
      m_mot = lvl;
    end
    m_crv = (m_zero_run >= int'(Crave)) ? 1 : 0;
  endtask

  task automatic step(input logic [1:0] lvl, input bit rst);
    @(negedge clk);
    dopamine_level = lvl;
    rst_n          = rst;
    @(posedge clk);
    model_edge(int'(lvl), rst);
    #1;
    chk("model_motivation", int'(motivation), m_mot);
    chk("model_reward", int'(reward_pulse), m_rew);
    chk("model_letdown", int'(letdown_pulse), m_let);
    chk("model_craving", int'(craving), m_crv);
`ifdef NT_DOPAMINE_READER_TREND_EN
    chk("model_trend", int'(trend), m_trend);
`endif
  endtask

  typedef struct {
    logic [1:0] lvl;
    bit         rst;
    int         mot;
    int         rew;
    int         let_p;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int lvl, input bit rst, input int mot, input int rew,
                              input int let_p);
    vec_t v;
    v.lvl   = 2'(lvl);
    v.rst   = rst;
    v.mot   = mot;
    v.rew   = rew;
    v.let_p = let_p;
    return v;
  endfunction

  initial begin
    int since;
    bit seen;
    logic [1:0] cur;

    dopamine_level = 2'd2;
    rst_n          = 1'b0;

    // Reset and hold at 2.
    vecs.push_back(mk(2, 0, 2, 0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 0));
    // 2 -> 3 debounce: commit on the fourth sample with a reward.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(3, 1, 2, 0, 0));
    vecs.push_back(mk(3, 1, 3, 1, 0));
    vecs.push_back(mk(3, 1, 3, 0, 0));
    // Two-cycle glitch to 2, then one-cycle glitch to 0: no pulses.
    vecs.push_back(mk(2, 1, 3, 0, 0));
    vecs.push_back(mk(2, 1, 3, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(3, 1, 3, 0, 0));
    // Down to 1.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1));
    // 1 -> 2 rewarded, then 2 -> 3 five cycles later is suppressed.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 1, 1, 0, 0));
    vecs.push_back(mk(2, 1, 2, 1, 0));
    vecs.push_back(mk(2, 1, 2, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(3, 1, 2, 0, 0));
    vecs.push_back(mk(3, 1, 3, 0, 0));
    // 3 -> 1 letdown is never suppressed.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 3, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1));
    // Reset in the middle of a window, then a clean restart.
    vecs.push_back(mk(0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 0));
    vecs.push_back(mk(2, 1, 2, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 2, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1));

    foreach (vecs[i]) begin
      step(vecs[i].lvl, vecs[i].rst);
      chk("vec_motivation", int'(motivation), vecs[i].mot);
      chk("vec_reward", int'(reward_pulse), vecs[i].rew);
      chk("vec_letdown", int'(letdown_pulse), vecs[i].let_p);
    end

    // Craving: hold 0 and measure edges from motivation reaching 0 to craving.
    since = -1;
    seen  = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step(2'd0, 1'b1);
      if (since >= 0) since++;
      if (motivation == 2'd0 && since < 0) since = 0;
      if (craving) seen = 1'b1;
    end
    chk("crave_seen", int'(seen), 1);
    chk("crave_latency", since, int'(Crave));
    for (int i = 0; i < 3; i++) step(2'd1, 1'b1);
    step(2'd1, 1'b1);
    chk("crave_at_commit", int'(craving), 1);
    chk("crave_commit_mot", int'(motivation), 1);
    step(2'd1, 1'b1);
    chk("crave_drop", int'(craving), 0);

    // Randomized runs, with occasional resets.
    cur = 2'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 2'($urandom_range(0, 3));
      step(cur, ($urandom_range(0, 299) != 0));
    end
    // Long zero stretch under random mode to exercise craving saturation.
    for (int i = 0; i < 260; i++) step(2'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(2'd3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
